noise_est_feeder: RTL and testbench

NOISE_EST_FEEDER -- requirements
Module: noise_est_feeder

---
 rtl/noise_est_feeder.sv | 119 +++++++++++
 tb/tb_noise_est_feeder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/noise_est_feeder.sv
// noise_est_feeder: turns AXI read beats of {pad,R,G,B} into an RGB-mean pixel stream with block/frame flags
module noise_est_feeder #(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = 8,
   parameter int BLOCK_SIZE      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_of_frame,
   input  logic [31:0]                blocks_per_frame,
   input  logic [DATA_WIDTH-1:0]      rdata,
   input  logic                       rvalid,
   input  logic                       rlast,
   output logic                       rready,
   output logic [BYTE_DATA_WIDTH-1:0] pixel_data,
   output logic                       pixel_valid,
   input  logic                       pixel_ready,
   output logic                       sob,
   output logic                       eob,
   output logic                       sof,
   output logic                       eof,
   output logic                       frame_done,
   output logic                       burst_error
);
   localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);
   localparam int BW = BYTE_DATA_WIDTH;
   localparam int SW = BW + 2;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col, row;
   logic [31:0]   blk, bpf;
   logic          out_free, accept, last_col, last_row, col_wrap;
   logic          sob_c, eob_c, sof_c, eof_c;
   logic [SW-1:0] sum;
   logic          unused_pad;

   assign out_free   = !pixel_valid || pixel_ready;
   assign accept     = rvalid && rready;
   assign last_col   = col == LAST;
   assign last_row   = row == LAST;
   assign col_wrap   = last_col || rlast;
   assign sob_c      = col == '0 && row == '0;
   assign eob_c      = last_col && last_row;
   assign sof_c      = sob_c && blk == '0;
   assign eof_c      = eob_c && blk == bpf - 32'd1;
   assign sum        = SW'(rdata[3*BW-1:2*BW]) + SW'(rdata[2*BW-1:BW]) + SW'(rdata[BW-1:0]);
   assign unused_pad = &{1'b0, rdata[DATA_WIDTH-1:3*BW]};

   // next state, read-channel ready and the end-of-frame pulse
   always_comb begin
      state_nxt  = state;
      rready     = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE:    state_nxt = start_of_frame ? STREAM : IDLE;
         STREAM: begin
            rready    = out_free;
            state_nxt = (rvalid && out_free && eof_c) ? DRAIN : STREAM;
         end
         DRAIN: begin
            frame_done = out_free;
            state_nxt  = out_free ? IDLE : DRAIN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // pixel position counters, frame length and sticky burst-shape error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col         <= '0;
         row         <= '0;
         blk         <= '0;
         bpf         <= '0;
         burst_error <= 1'b0;
      end else if (state == IDLE && start_of_frame) begin
         col         <= '0;
         row         <= '0;
         blk         <= '0;
         bpf         <= (blocks_per_frame == 32'd0) ? 32'd1 : blocks_per_frame;
         burst_error <= 1'b0;
      end else if (accept) begin
         col <= col_wrap ? '0 : col + 1'b1;
         row <= col_wrap ? (last_row ? '0 : row + 1'b1) : row;
         blk <= (col_wrap && last_row) ? blk + 32'd1 : blk;
         if (last_col != rlast) burst_error <= 1'b1;
      end
   end

   // output register: mean pixel and flags captured at accept, valid held until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         sob         <= 1'b0;
         eob         <= 1'b0;
         sof         <= 1'b0;
         eof         <= 1'b0;
      end else if (accept) begin
         pixel_data  <= BW'(sum / SW'(3));
         pixel_valid <= 1'b1;
         sob         <= sob_c;
         eob         <= eob_c;
         sof         <= sof_c;
         eof         <= eof_c;
      end else if (pixel_ready) begin
         pixel_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_noise_est_feeder.sv
// tb_noise_est_feeder: table vectors plus randomized frames checked against a position-based reference model
module tb_noise_est_feeder;
   logic        clk = 1'b0, rst_n = 1'b0, start_of_frame = 1'b0;
   logic [31:0] blocks_per_frame = '0, rdata = '0;
   logic        rvalid = 1'b0, rlast = 1'b0, rready;
   logic [7:0]  pixel_data;
   logic        pixel_valid, pixel_ready = 1'b1;
   logic        sob, eob, sof, eof, frame_done, burst_error;

   typedef struct {logic [7:0] d; bit sob, eob, sof, eof;} pix_t;
   typedef struct {logic [31:0] d; logic [7:0] exp;} vec_t;

   pix_t exp_q[$];
   vec_t tab[8];
   int   errors = 0, checks = 0, frames = 0, pos = 0, bpf_m = 1;
   bit   toggle = 1'b0;
   bit   ok, is_eof;
   int   nb, f0;

   always #5 clk = ~clk;

   noise_est_feeder dut (
      .clk(clk), .rst_n(rst_n), .start_of_frame(start_of_frame), .blocks_per_frame(blocks_per_frame),
      .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .sob(sob), .eob(eob), .sof(sof), .eof(eof), .frame_done(frame_done), .burst_error(burst_error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] avg(input logic [31:0] d);
      return 8'((int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0])) / 3);
   endfunction

   // consumer side: pop the model on every output handshake, and watch the stall rule
   always @(negedge clk) begin
      pix_t e;
      #2;
      if (rst_n) begin
         if (pixel_valid && !pixel_ready) check("rready_during_stall", rready, 0);
         if (frame_done) frames++;
         if (pixel_valid && pixel_ready) begin
            if (exp_q.size() == 0) check("extra_pixel", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("pixel", {pixel_data, sob, eob, sof, eof}, {e.d, e.sob, e.eob, e.sof, e.eof});
            end
         end
      end
   end

   always @(negedge clk) if (toggle) pixel_ready = ~pixel_ready;

   task automatic arm(input int n);
      start_of_frame   = 1'b1;
      blocks_per_frame = n;
      @(negedge clk);
      start_of_frame = 1'b0;
      bpf_m = (n == 0) ? 1 : n;
      pos   = 0;
   endtask

   task automatic send(input logic [31:0] d, input bit l, output bit acc);
      rdata = d; rvalid = 1'b1; rlast = l; acc = 1'b0;
      for (int n = 0; n < 100 && !acc; n++) begin
         #1 acc = rready;
         @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0;
      check("beat_accepted", acc, 1);
   endtask

   task automatic do_beat(input logic [31:0] d, input bit l, output bit acc, output bit last_px);
      pix_t e;
      int w, b;
      w = pos % 64; b = pos / 64;
      e.d = avg(d); e.sob = (w == 0); e.eob = (w == 63);
      e.sof = e.sob && b == 0; e.eof = e.eob && b == bpf_m - 1;
      exp_q.push_back(e);
      send(d, l, acc);
      pos = (l || pos % 8 == 7) ? (pos / 8 + 1) * 8 : pos + 1;
      last_px = e.eof;
   endtask

   task automatic run_frame(input bit gray, input int early_at, input int miss_at, input int stop_at, output int beats);
      bit a = 1'b1, fin = 1'b0, l;
      logic [31:0] d;
      beats = 0;
      while (a && !fin && beats != stop_at && beats < 2000) begin
         d = $urandom;
         if (gray) d = {8'h00, d[7:0], d[7:0], d[7:0]};
         l = ((pos % 8 == 7) && beats != miss_at) || beats == early_at;
         do_beat(d, l, a, fin);
         beats++;
      end
   endtask

   task automatic end_frame(input int fstart);
      repeat (20) @(negedge clk);
      check("frame_done_count", frames - fstart, 1);
      check("all_pixels_out", exp_q.size(), 0);
   endtask

   initial begin
      tab[0] = '{32'h002E12FD, 8'd105};
      tab[1] = '{32'h00000000, 8'd0};
      tab[2] = '{32'h00FFFFFF, 8'd255};
      tab[3] = '{32'hFF000000, 8'd0};
      tab[4] = '{32'h00010203, 8'd2};
      tab[5] = '{32'h00FFFF00, 8'd170};
      tab[6] = '{32'h00000001, 8'd0};
      tab[7] = '{32'hAB0A0B0C, 8'd11};

      repeat (3) @(negedge clk);
      check("reset_outputs", {rready, pixel_valid, pixel_data, sob, eob, sof, eof, frame_done, burst_error}, 0);
      rst_n = 1'b1;
      rvalid = 1'b1; rdata = 32'h00123456;
      for (int i = 0; i < 5; i++) begin
         #1 check("idle_no_accept", rready, 0);
         @(negedge clk);
      end
      rvalid = 1'b0;

      f0 = frames;
      arm(1);
      for (int i = 0; i < 8; i++) begin
         do_beat(tab[i].d, i == 7, ok, is_eof);
         check("table_avg", {pixel_valid, pixel_data}, {1'b1, tab[i].exp});
      end
      run_frame(0, -1, -1, -1, nb);
      check("table_frame_beats", nb, 56);
      end_frame(f0);

      f0 = frames;
      arm(4);
      check("err_clear_on_arm", burst_error, 0);
      run_frame(1, -1, -1, -1, nb);
      check("gray_frame_beats", nb, 256);
      end_frame(f0);
      check("gray_no_error", burst_error, 0);

      f0 = frames;
      toggle = 1'b1;
      arm(1);
      run_frame(0, -1, -1, 20, nb);
      start_of_frame = 1'b1; blocks_per_frame = 0;
      @(negedge clk);
      start_of_frame = 1'b0;
      run_frame(0, -1, -1, -1, nb);
      check("toggle_rest_beats", nb, 44);
      end_frame(f0);
      toggle = 1'b0;
      pixel_ready = 1'b1;

      f0 = frames;
      arm(1);
      run_frame(0, 13, -1, 14, nb);
      check("early_rlast_err", burst_error, 1);
      run_frame(0, -1, -1, -1, nb);
      check("early_rlast_rest", nb, 48);
      end_frame(f0);
      check("err_sticky", burst_error, 1);
      f0 = frames;
      arm(1);
      check("err_cleared", burst_error, 0);
      run_frame(0, -1, 31, -1, nb);
      end_frame(f0);
      check("missing_rlast_err", burst_error, 1);

      arm(4);
      run_frame(0, -1, -1, 100, nb);
      #3 rst_n = 1'b0;
      #1 check("midframe_reset", {rready, pixel_valid, pixel_data, sob, eob, sof, eof, frame_done, burst_error}, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      f0 = frames;
      arm(4);
      run_frame(0, -1, -1, -1, nb);
      check("post_reset_beats", nb, 256);
      end_frame(f0);

      f0 = frames;
      arm(0);
      run_frame(0, -1, -1, -1, nb);
      check("bpf0_beats", nb, 64);
      end_frame(f0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
